// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder/subtractor controller:
//   state_e       - controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width in bits
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_if
// Start/busy/done request bus of the bit-serial adder/subtractor.
//   master : drives start, Sub, A, B, Cin; observes busy, done, S, Cout, V
//   slave  : the controller side (mirror of master)
// -----------------------------------------------------------------------------
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output start, Sub, A, B, Cin,
    input  busy, done, S, Cout, V
  );

  modport slave (
    input  start, Sub, A, B, Cin,
    output busy, done, S, Cout, V
  );

endinterface : serial_add_if

// File: rtl/serial_add_ctrl_sc.sv
// -----------------------------------------------------------------------------
// SC
// One-bit full-adder cell used as the single datapath slice.
//   A, B  : operand bits
//   Cin   : carry in
//   S     : sum bit
//   Cout  : carry out
// -----------------------------------------------------------------------------
module SC (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic S
);

  logic prop_s;

  assign prop_s = A ^ B;
  assign S      = prop_s ^ Cin;
  assign Cout   = (A & B) | (Cin & prop_s);

endmodule : SC

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder/subtractor: one full-adder cell is reused over WIDTH
// cycles, LSB first, with the carry held in a flip-flop between slices.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : serial_add_if.slave (start/Sub/A/B/Cin in, busy/done/S/Cout/V out)
// A request is accepted in IDLE or DONE; done pulses WIDTH+1 cycles after
// the accepting edge's cycle and S/Cout/V then hold until the next accept.
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  serial_add_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_r;
  logic [WIDTH-1:0]   rega_r;
  logic [WIDTH-1:0]   regb_r;
  logic [WIDTH-1:0]   res_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               cmsb_r;     // carry into the MSB slice, for V
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   s_r;
  logic               cout_r;
  logic               v_r;

  logic               cell_sum_s;
  logic               cell_cout_s;
  logic [WIDTH-1:0]   res_next_s;

  SC u_sc (
    .A    (rega_r[0]),
    .B    (regb_r[0]),
    .Cin  (carry_r),
    .Cout (cell_cout_s),
    .S    (cell_sum_s)
  );

  // Result register shifts right, new sum bit enters at the MSB.
  assign res_next_s = WIDTH'({cell_sum_s, res_r} >> 1);

  // Sequencer: operand capture, per-slice shifting and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      rega_r  <= '0;
      regb_r  <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      cmsb_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      v_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // Subtract as A + ~B + 1; Cin is ignored in that mode.
            rega_r  <= bus.A;
            regb_r  <= bus.Sub ? ~bus.B : bus.B;
            carry_r <= bus.Sub ? 1'b1 : bus.Cin;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          res_r   <= res_next_s;
          rega_r  <= rega_r >> 1;
          regb_r  <= regb_r >> 1;
          carry_r <= cell_cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WIDTH - 2)) begin
            cmsb_r <= cell_cout_s;
          end else begin
            cmsb_r <= cmsb_r;
          end
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            // Last slice: publish the full result in one step.
            s_r     <= res_next_s;
            cout_r  <= cell_cout_s;
            v_r     <= cmsb_r ^ cell_cout_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = s_r;
  assign bus.Cout = cout_r;
  assign bus.V    = v_r;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed self-checking bench for serial_add_ctrl with WIDTH = 8.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   lat;
  int   nbusy;
  int   saw_done;

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive a request and let the accepting edge pass.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.Sub   = sub;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count edges (and busy cycles) until done, bounded at 20 edges.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) nb++;
      tick();
      n++;
    end
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'h3C;
    bus.B     = 8'h5A;
    bus.Cin   = 1'b0;
    bus.Sub   = 1'b0;

    // 1. Reset held two cycles with start high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_S",    {24'd0, bus.S},    32'h00);
      check("rst_Cout", {31'd0, bus.Cout}, 32'd0);
      check("rst_V",    {31'd0, bus.V},    32'd0);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // 2. 0x3C + 0x5A: done 8 edges after the accepting edge, busy 8 cycles.
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    check("add_busy_first", {31'd0, bus.busy}, 32'd1);
    wait_done(lat, nbusy);
    check("add_latency", lat,   32'd8);
    check("add_nbusy",   nbusy, 32'd8);
    check("add_S",    {24'd0, bus.S},    32'h96);
    check("add_Cout", {31'd0, bus.Cout}, 32'd0);
    check("add_V",    {31'd0, bus.V},    32'd1);
    check("add_busy_done", {31'd0, bus.busy}, 32'd0);
    tick();
    check("add_done_pulse", {31'd0, bus.done}, 32'd0);
    check("add_S_hold",     {24'd0, bus.S},    32'h96);

    // 3. Wrap-around and carry-in.
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat, nbusy);
    check("wrap_latency", lat, 32'd8);
    check("wrap_S",    {24'd0, bus.S},    32'h00);
    check("wrap_Cout", {31'd0, bus.Cout}, 32'd1);
    check("wrap_V",    {31'd0, bus.V},    32'd0);
    tick();
    start_op(8'h00, 8'h00, 1'b1, 1'b0);
    wait_done(lat, nbusy);
    check("cin_S",    {24'd0, bus.S},    32'h01);
    check("cin_Cout", {31'd0, bus.Cout}, 32'd0);
    check("cin_V",    {31'd0, bus.V},    32'd0);
    tick();

    // 4. Subtraction (Cin ignored).
    start_op(8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(lat, nbusy);
    check("sub1_S",    {24'd0, bus.S},    32'hFE);
    check("sub1_Cout", {31'd0, bus.Cout}, 32'd0);
    check("sub1_V",    {31'd0, bus.V},    32'd0);
    tick();
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(lat, nbusy);
    check("sub2_S",    {24'd0, bus.S},    32'h7F);
    check("sub2_Cout", {31'd0, bus.Cout}, 32'd1);
    check("sub2_V",    {31'd0, bus.V},    32'd1);
    tick();

    // 5a. start pulsed mid-RUN with different operands is ignored.
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    tick();
    tick();
    bus.A     = 8'h11;
    bus.B     = 8'h22;
    bus.Sub   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat, nbusy);
    check("ign_latency", lat, 32'd5);
    check("ign_S",    {24'd0, bus.S},    32'h96);
    check("ign_Cout", {31'd0, bus.Cout}, 32'd0);

    // 5b. start held in the DONE cycle: back-to-back, next done 9 cycles on.
    bus.A     = 8'hFF;
    bus.B     = 8'h01;
    bus.Cin   = 1'b0;
    bus.Sub   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b_busy",   {31'd0, bus.busy}, 32'd1);
    check("b2b_S_hold", {24'd0, bus.S},    32'h96);
    tick();
    tick();
    tick();
    check("b2b_S_mid",  {24'd0, bus.S},    32'h96);
    wait_done(lat, nbusy);
    check("b2b_latency", lat, 32'd5);
    check("b2b_S",    {24'd0, bus.S},    32'h00);
    check("b2b_Cout", {31'd0, bus.Cout}, 32'd1);
    tick();

    // 6. Reset on the 4th RUN cycle aborts the operation.
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_done", {31'd0, bus.done}, 32'd0);
    check("mrst_S",    {24'd0, bus.S},    32'h00);
    check("mrst_Cout", {31'd0, bus.Cout}, 32'd0);
    check("mrst_V",    {31'd0, bus.V},    32'd0);
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done++;
    end
    check("mrst_quiet", saw_done, 32'd0);
    start_op(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(lat, nbusy);
    check("fresh_latency", lat, 32'd8);
    check("fresh_S",    {24'd0, bus.S},    32'hFE);
    check("fresh_Cout", {31'd0, bus.Cout}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_serial_add_ctrl
